// File: rtl/addr_gen_if.sv
// Controller/memory-side bundle of the address generator: PC control, operand channels,
// request/select and the registered address response.
interface addr_gen_if #(
    parameter int WIDTH   = 5,
    parameter int NUM_SRC = 2
);
    localparam int SELW = $clog2(NUM_SRC + 1);

    logic                     pc_ld;
    logic [WIDTH-1:0]         pc_ld_val;
    logic                     pc_inc;
    logic [NUM_SRC*WIDTH-1:0] op_addr;
    logic                     addr_req;
    logic [SELW-1:0]          src_sel;
    logic [WIDTH-1:0]         addr_out;
    logic                     addr_valid;
    logic                     sel_err;
    logic [WIDTH-1:0]         pc_out;

    modport master (
        output pc_ld, pc_ld_val, pc_inc, op_addr, addr_req, src_sel,
        input  addr_out, addr_valid, sel_err, pc_out
    );

    modport slave (
        input  pc_ld, pc_ld_val, pc_inc, op_addr, addr_req, src_sel,
        output addr_out, addr_valid, sel_err, pc_out
    );
endinterface

// File: rtl/addr_gen_unit.sv
// Registered PC / operand-address generator with one-cycle valid strobe.
// Optional upper address bound check enabled by defining ADDR_LIMIT_EN.
module addr_gen_lane #(
    parameter int WIDTH = 5,
    parameter int SELW  = 2,
    parameter int IDX   = 0
) (
    input  logic [SELW-1:0]  sel,
    input  logic [WIDTH-1:0] addr,
    output logic             hit,
    output logic [WIDTH-1:0] masked
);
    // Channel IDX answers to select code IDX+1; code 0 belongs to the PC.
    assign hit    = (sel == SELW'(IDX + 1));
    assign masked = hit ? addr : '0;
endmodule

module addr_gen_unit #(
    parameter int               WIDTH     = 5,
    parameter int               NUM_SRC   = 2,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               SELW      = $clog2(NUM_SRC + 1)
`ifdef ADDR_LIMIT_EN
    ,
    parameter logic [WIDTH-1:0] ADDR_LIMIT = '1
`endif
) (
    input  logic     clk,
    input  logic     rst,
    addr_gen_if.slave bus
`ifdef ADDR_LIMIT_EN
    ,
    output logic     limit_fault,
    input  logic     fault_clr
`endif
);
    typedef struct packed {
        logic [WIDTH-1:0] addr;
        logic             valid;
        logic             err;
    } rsp_t;

    logic [WIDTH-1:0]                pc_q;
    logic [WIDTH-1:0]                pc_nxt;
    logic [SELW-1:0]                 sel;
    logic [NUM_SRC-1:0][WIDTH-1:0]   ch;
    logic [NUM_SRC-1:0][WIDTH-1:0]   ch_masked;
    logic [NUM_SRC-1:0]              ch_hit;
    logic [WIDTH-1:0]                sel_addr;
    logic                            sel_legal;
    logic                            over_limit;
    logic                            accept;
    rsp_t                            rsp_q;

    assign sel       = bus.src_sel;
    assign sel_legal = (sel <= SELW'(NUM_SRC));

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_lane
        assign ch[k] = bus.op_addr[k*WIDTH +: WIDTH];
        addr_gen_lane #(.WIDTH(WIDTH), .SELW(SELW), .IDX(k)) u_lane (
            .sel    (sel),
            .addr   (ch[k]),
            .hit    (ch_hit[k]),
            .masked (ch_masked[k])
        );
    end

    // At most one lane hits, so an OR of the masked lanes is the mux.
    always_comb begin
        sel_addr = (sel == '0) ? pc_q : '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            sel_addr = sel_addr | ch_masked[k];
        end
    end

`ifdef ADDR_LIMIT_EN
    assign over_limit = (sel_addr > ADDR_LIMIT);
`else
    assign over_limit = 1'b0;
`endif

    assign accept = bus.addr_req && sel_legal && !over_limit;

    always_comb begin
        pc_nxt = pc_q;
        if (bus.pc_ld) begin
            pc_nxt = bus.pc_ld_val;
        end else if (bus.pc_inc) begin
            pc_nxt = pc_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_nxt;
        end
    end

    // A fetch samples pc_q, i.e. the PC before this edge's update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_q <= '0;
        end else begin
            if (accept) begin
                rsp_q.addr <= sel_addr;
            end
            rsp_q.valid <= accept;
            rsp_q.err   <= bus.addr_req && !sel_legal;
        end
    end

`ifdef ADDR_LIMIT_EN
    // Sticky fault; a new violation beats a clear on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit_fault <= 1'b0;
        end else if (bus.addr_req && sel_legal && over_limit) begin
            limit_fault <= 1'b1;
        end else if (fault_clr) begin
            limit_fault <= 1'b0;
        end
    end
`endif

    assign bus.addr_out   = rsp_q.addr;
    assign bus.addr_valid = rsp_q.valid;
    assign bus.sel_err    = rsp_q.err;
    assign bus.pc_out     = pc_q;

    logic unused_ok;
    assign unused_ok = ^ch_hit;
endmodule
